dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (program loader/debug).

---
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter for single-port dmem with read-modify-write for sub-word stores
module dmem_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int MEM_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic        req0_we_i,
    input  logic [3:0]  req0_be_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_wdata_i,
    output logic        rsp0_valid_o,
    output logic [31:0] rsp0_rdata_o,
    output logic        rsp0_err_o,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic        req1_we_i,
    input  logic [3:0]  req1_be_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_wdata_i,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp1_rdata_o,
    output logic        rsp1_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR} state_t;
    state_t      state_q, state_d;
    logic        last_q, id_q, we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q, merge_q, merge_d, mask;
    logic        rsp0_valid_q, rsp1_valid_q, rsp0_err_q, rsp1_err_q;
    logic [31:0] rsp0_rdata_q, rsp1_rdata_q, rdata_d;
    logic        gnt1, accept, in_range, partial, fire, err_d;

    // Port 1 wins when alone, or under round-robin when port 0 was served last
    assign gnt1     = req1_valid_i && (!req0_valid_i || (ROUND_ROBIN && !last_q));
    assign accept   = req0_ready_o || req1_ready_o;
    assign in_range = {2'b00, addr_q[31:2]} < 32'(MEM_WORDS);
    assign partial  = we_q && in_range && be_q != 4'hF && be_q != 4'h0;
    assign mask     = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    assign mem_addr_o   = addr_q;
    assign rsp0_valid_o = rsp0_valid_q;
    assign rsp1_valid_o = rsp1_valid_q;
    assign rsp0_rdata_o = rsp0_rdata_q;
    assign rsp1_rdata_o = rsp1_rdata_q;
    assign rsp0_err_o   = rsp0_err_q;
    assign rsp1_err_o   = rsp1_err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: partial stores take an extra cycle to write the merged word
    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? ACCESS : IDLE) :
                  (state_q == ACCESS && partial) ? RMW_WR : IDLE;
    end

    // Outputs: grant/ready, memory write strobe and data, response strobe
    always_comb begin
        req0_ready_o = !rst && state_q == IDLE && req0_valid_i && !gnt1;
        req1_ready_o = !rst && state_q == IDLE && gnt1;
        mem_we_o     = !rst && ((state_q == ACCESS && in_range && we_q && be_q == 4'hF) || state_q == RMW_WR);
        mem_wdata_o  = (state_q == RMW_WR) ? merge_q : wdata_q;
        merge_d      = (wdata_q & mask) | (mem_rdata_i & ~mask);
        fire         = (state_q == ACCESS && !partial) || state_q == RMW_WR;
        rdata_d      = (state_q == ACCESS && in_range && !we_q) ? mem_rdata_i : 32'h0;
        err_d        = state_q == ACCESS && !in_range;
    end

    // Request latch, merge word and registered per-port responses
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= 32'h0;
            rsp1_rdata_q <= 32'h0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                id_q    <= req1_ready_o;
                last_q  <= req1_ready_o;
                we_q    <= req1_ready_o ? req1_we_i : req0_we_i;
                be_q    <= req1_ready_o ? req1_be_i : req0_be_i;
                addr_q  <= req1_ready_o ? req1_addr_i : req0_addr_i;
                wdata_q <= req1_ready_o ? req1_wdata_i : req0_wdata_i;
            end
            if (state_q == ACCESS) merge_q <= merge_d;
            rsp0_valid_q <= fire && !id_q;
            rsp1_valid_q <= fire && id_q;
            rsp0_rdata_q <= (fire && !id_q) ? rdata_d : 32'h0;
            rsp1_rdata_q <= (fire && id_q) ? rdata_d : 32'h0;
            rsp0_err_q   <= fire && !id_q && err_d;
            rsp1_err_q   <= fire && id_q && err_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test of dmem_arbiter with a behavioural dmem model
module tb_dmem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        r0_valid = 0, r0_we = 0, r1_valid = 0, r1_we = 0;
    logic [3:0]  r0_be = 0, r1_be = 0;
    logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
    logic        rdy0, rdy1, v0, v1, e0, e1, mem_we;
    logic [31:0] d0, d1, mem_addr, mem_wdata, mem_rdata;
    logic        f_rdy0, f_rdy1, f_v0, f_v1, f_e0, f_e1, f_we;
    logic [31:0] f_d0, f_d1, f_addr, f_wdata;
    logic [31:0] mem [0:1023];
    logic        pre_we = 0;
    logic [9:0]  pre_idx = 0;
    logic [31:0] pre_val = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_val;
    end

    dmem_arbiter #(.ROUND_ROBIN(1'b1), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(r0_valid), .req0_ready_o(rdy0), .req0_we_i(r0_we), .req0_be_i(r0_be),
        .req0_addr_i(r0_addr), .req0_wdata_i(r0_wdata),
        .rsp0_valid_o(v0), .rsp0_rdata_o(d0), .rsp0_err_o(e0),
        .req1_valid_i(r1_valid), .req1_ready_o(rdy1), .req1_we_i(r1_we), .req1_be_i(r1_be),
        .req1_addr_i(r1_addr), .req1_wdata_i(r1_wdata),
        .rsp1_valid_o(v1), .rsp1_rdata_o(d1), .rsp1_err_o(e1),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    dmem_arbiter #(.ROUND_ROBIN(1'b0), .MEM_WORDS(1024)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid_i(r0_valid), .req0_ready_o(f_rdy0), .req0_we_i(r0_we), .req0_be_i(r0_be),
        .req0_addr_i(r0_addr), .req0_wdata_i(r0_wdata),
        .rsp0_valid_o(f_v0), .rsp0_rdata_o(f_d0), .rsp0_err_o(f_e0),
        .req1_valid_i(r1_valid), .req1_ready_o(f_rdy1), .req1_we_i(r1_we), .req1_be_i(r1_be),
        .req1_addr_i(r1_addr), .req1_wdata_i(r1_wdata),
        .rsp1_valid_o(f_v1), .rsp1_rdata_o(f_d1), .rsp1_err_o(f_e1),
        .mem_we_o(f_we), .mem_addr_o(f_addr), .mem_wdata_o(f_wdata), .mem_rdata_i(32'h0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        pre_we = 1; pre_idx = idx; pre_val = val;
        step();
        pre_we = 0;
    endtask

    // Present a request, wait (bounded) for ready, then return at the negedge of the ACCESS cycle
    task automatic req(input bit p, input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        if (p) begin r1_valid = 1; r1_we = we; r1_be = be; r1_addr = a; r1_wdata = d; end
        else   begin r0_valid = 1; r0_we = we; r0_be = be; r0_addr = a; r0_wdata = d; end
        #1;
        while (!(p ? rdy1 : rdy0) && n < 8) begin step(); n++; end
        chk("accept", {31'h0, p ? rdy1 : rdy0}, 32'h1);
        step();
        r0_valid = 0; r1_valid = 0;
    endtask

    initial begin
        @(negedge clk);
        preload(10'd4, 32'hDEADBEEF);
        preload(10'd2, 32'h11223344);
        preload(10'd0, 32'h55555555);
        preload(10'd1023, 32'h0BADC0DE);
        preload(10'd12, 32'h12345678);
        chk("rst_rsp0_valid", {31'h0, v0}, 32'h0);
        chk("rst_rsp1_valid", {31'h0, v1}, 32'h0);
        chk("rst_rsp0_rdata", d0, 32'h0);
        chk("rst_rsp1_err", {31'h0, e1}, 32'h0);
        r0_valid = 1; r1_valid = 1; #1;
        chk("rst_ready0", {31'h0, rdy0}, 32'h0);
        chk("rst_ready1", {31'h0, rdy1}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        r0_valid = 0; r1_valid = 0;
        rst = 0;
        step();
        // Read
        req(0, 0, 4'h0, 32'h10, 32'h0);
        chk("rd_t1_rsp0", {31'h0, v0}, 32'h0);
        step();
        chk("rd_rsp0_valid", {31'h0, v0}, 32'h1);
        chk("rd_rsp0_rdata", d0, 32'hDEADBEEF);
        chk("rd_rsp0_err", {31'h0, e0}, 32'h0);
        chk("rd_rsp1_valid", {31'h0, v1}, 32'h0);
        // Partial store via read-modify-write
        req(1, 1, 4'b0010, 32'h8, 32'h0000AA00);
        chk("rmw_t1_we", {31'h0, mem_we}, 32'h0);
        chk("rmw_t1_rsp1", {31'h0, v1}, 32'h0);
        step();
        chk("rmw_t2_we", {31'h0, mem_we}, 32'h1);
        chk("rmw_t2_wdata", mem_wdata, 32'h1122AA44);
        chk("rmw_t2_addr", mem_addr, 32'h8);
        chk("rmw_t2_rsp1", {31'h0, v1}, 32'h0);
        step();
        chk("rmw_t3_rsp1", {31'h0, v1}, 32'h1);
        chk("rmw_t3_rdata", d1, 32'h0);
        chk("rmw_t3_we", {31'h0, mem_we}, 32'h0);
        chk("rmw_mem", mem[2], 32'h1122AA44);
        // Full store then read back
        req(0, 1, 4'hF, 32'h20, 32'hCAFEF00D);
        chk("wr_t1_we", {31'h0, mem_we}, 32'h1);
        chk("wr_t1_wdata", mem_wdata, 32'hCAFEF00D);
        chk("wr_t1_addr", mem_addr, 32'h20);
        step();
        chk("wr_rsp0_valid", {31'h0, v0}, 32'h1);
        chk("wr_t2_we", {31'h0, mem_we}, 32'h0);
        chk("wr_mem", mem[8], 32'hCAFEF00D);
        req(0, 0, 4'h0, 32'h20, 32'h0);
        step();
        chk("rb_rdata", d0, 32'hCAFEF00D);
        // Out of range and last in-range word
        req(0, 0, 4'h0, 32'h1000, 32'h0);
        chk("err_we", {31'h0, mem_we}, 32'h0);
        step();
        chk("err_valid", {31'h0, v0}, 32'h1);
        chk("err_flag", {31'h0, e0}, 32'h1);
        chk("err_rdata", d0, 32'h0);
        req(1, 0, 4'h0, 32'hFFC, 32'h0);
        step();
        chk("top_err", {31'h0, e1}, 32'h0);
        chk("top_rdata", d1, 32'h0BADC0DE);
        req(1, 1, 4'hF, 32'h1000, 32'hFFFFFFFF);
        chk("err_wr_we", {31'h0, mem_we}, 32'h0);
        step();
        chk("err_wr_flag", {31'h0, e1}, 32'h1);
        // Write with no byte enables acknowledges only
        req(1, 1, 4'h0, 32'h30, 32'hFFFFFFFF);
        chk("be0_we", {31'h0, mem_we}, 32'h0);
        step();
        chk("be0_rsp1", {31'h0, v1}, 32'h1);
        chk("be0_err", {31'h0, e1}, 32'h0);
        chk("be0_mem", mem[12], 32'h12345678);
        // Contention: both ports valid continuously, from reset
        rst = 1;
        step();
        rst = 0;
        r0_we = 0; r0_addr = 32'h10; r1_we = 0; r1_addr = 32'h8;
        r0_valid = 1; r1_valid = 1; #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_rdy0_%0d", i), {31'h0, rdy0}, {31'h0, i % 4 == 0});
            chk($sformatf("rr_rdy1_%0d", i), {31'h0, rdy1}, {31'h0, i % 4 == 2});
            chk($sformatf("rr_rsp0_%0d", i), {31'h0, v0}, {31'h0, i % 4 == 2});
            chk($sformatf("rr_rsp1_%0d", i), {31'h0, v1}, {31'h0, i % 4 == 0 && i > 0});
            chk($sformatf("fp_rdy0_%0d", i), {31'h0, f_rdy0}, {31'h0, i % 2 == 0});
            chk($sformatf("fp_rdy1_%0d", i), {31'h0, f_rdy1}, 32'h0);
            step();
        end
        r0_valid = 0; r1_valid = 0;
        chk("rr_last_rsp1", {31'h0, v1}, 32'h1);
        chk("rr_last_rdata", d1, 32'h1122AA44);
        step();
        // Reset during ACCESS of a partial store
        req(1, 1, 4'b0001, 32'h8, 32'h000000FF);
        rst = 1; #1;
        chk("rstm_we_a", {31'h0, mem_we}, 32'h0);
        step();
        chk("rstm_we_b", {31'h0, mem_we}, 32'h0);
        chk("rstm_rsp1_b", {31'h0, v1}, 32'h0);
        rst = 0;
        step();
        chk("rstm_we_c", {31'h0, mem_we}, 32'h0);
        chk("rstm_rsp1_c", {31'h0, v1}, 32'h0);
        chk("rstm_rsp0_c", {31'h0, v0}, 32'h0);
        chk("rstm_rdata_c", d1, 32'h0);
        step();
        chk("rstm_rsp1_d", {31'h0, v1}, 32'h0);
        chk("rstm_mem", mem[2], 32'h1122AA44);
        req(1, 0, 4'h0, 32'h8, 32'h0);
        step();
        chk("rstm_readback", d1, 32'h1122AA44);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
